alu_ctrl_seq: RTL

Registered, handshaked successor to the combinational ALU control decoder. Decodes the full RV32I/M `aluop`/`funct3`/`funct7` space into a widened ALU operation code. Sequences multi-cycle multiply/divide ops by issuing a start pulse and counting a fixed latency. Sits between the main control unit (upstream valid/ready) and the ALU/mul-div datapath (downstream valid/ready), and supplies the stall for the execute stage.

---
 rtl/alu_pkg.sv | 62 ++++++
 rtl/alu_decode.sv | 79 +++++++
 rtl/alu_ctrl_seq.sv | 122 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the sequenced ALU control decoder.
package alu_pkg;

  // Main-control ALU class: load/store, branch, R-type, I-type.
  typedef enum logic [1:0] {
    LS = 2'b00,
    BR = 2'b01,
    RT = 2'b10,
    IT = 2'b11
  } aluop_t;

  // Widened ALU operation codes; M ops occupy 16..23.
  typedef enum logic [4:0] {
    OP_AND    = 5'd0,
    OP_OR     = 5'd1,
    OP_ADD    = 5'd2,
    OP_XOR    = 5'd3,
    OP_SLL    = 5'd4,
    OP_SRL    = 5'd5,
    OP_SUB    = 5'd6,
    OP_SRA    = 5'd7,
    OP_SLT    = 5'd8,
    OP_SLTU   = 5'd9,
    OP_MUL    = 5'd16,
    OP_MULH   = 5'd17,
    OP_MULHSU = 5'd18,
    OP_MULHU  = 5'd19,
    OP_DIV    = 5'd20,
    OP_DIVU   = 5'd21,
    OP_REM    = 5'd22,
    OP_REMU   = 5'd23
  } alu_op_t;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;
  localparam logic [6:0] FUNCT7_MD   = 7'b0000001;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MD_RUN = 2'd1,
    ST_OUT    = 2'd2
  } state_t;

  // Base integer op selected by funct3 when funct7 is all zeros.
  function automatic alu_op_t base_op(input logic [2:0] f3);
    alu_op_t r;
    case (f3)
      3'b000:  r = OP_ADD;
      3'b001:  r = OP_SLL;
      3'b010:  r = OP_SLT;
      3'b011:  r = OP_SLTU;
      3'b100:  r = OP_XOR;
      3'b101:  r = OP_SRL;
      3'b110:  r = OP_OR;
      3'b111:  r = OP_AND;
      default: r = OP_ADD;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_decode.sv
// Purely combinational decode of aluop/funct3/funct7 into an ALU op code.
// Illegal encodings report ADD with illegal set and is_md clear.
module alu_decode
  import alu_pkg::*;
#(
  parameter bit MD_EN = 1'b1
) (
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output alu_op_t    op,
  output logic       is_md,
  output logic       illegal
);

  // Decode table; op is only overwritten on legal paths so illegal keeps ADD.
  always_comb begin
    op      = OP_ADD;
    is_md   = 1'b0;
    illegal = 1'b0;
    case (aluop_t'(aluop))
      LS: op = OP_ADD;
      BR: begin
        case (funct3[2:1])
          2'b00:   op = OP_SUB;
          2'b10:   op = OP_SLT;
          2'b11:   op = OP_SLTU;
          default: illegal = 1'b1;
        endcase
      end
      RT: begin
        if (funct7 == FUNCT7_BASE) begin
          op = base_op(funct3);
        end else if (funct7 == FUNCT7_ALT) begin
          if (funct3 == 3'b000) begin
            op = OP_SUB;
          end else if (funct3 == 3'b101) begin
            op = OP_SRA;
          end else begin
            illegal = 1'b1;
          end
        end else if (funct7 == FUNCT7_MD) begin
          if (MD_EN) begin
            op    = alu_op_t'({2'b10, funct3});
            is_md = 1'b1;
          end else begin
            illegal = 1'b1;
          end
        end else begin
          illegal = 1'b1;
        end
      end
      IT: begin
        case (funct3)
          3'b000: op = OP_ADD;
          3'b001: begin
            if (funct7 == FUNCT7_BASE) begin
              op = OP_SLL;
            end else begin
              illegal = 1'b1;
            end
          end
          3'b101: begin
            if (funct7 == FUNCT7_BASE) begin
              op = OP_SRL;
            end else if (funct7 == FUNCT7_ALT) begin
              op = OP_SRA;
            end else begin
              illegal = 1'b1;
            end
          end
          default: op = base_op(funct3);
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered, handshaked ALU control decoder. Non-M ops complete in one
// cycle; M ops issue a start pulse and stall for a fixed latency.
module alu_ctrl_seq
  import alu_pkg::*;
#(
  parameter int OP_W   = 5,
  parameter bit MD_EN  = 1'b1,
  parameter int MD_LAT = 33
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      aluop,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OP_W-1:0] aluoperation,
  output logic            is_md,
  output logic            illegal,
  output logic            md_start,
  output logic            md_busy
);

  localparam int              CNT_W    = $clog2(MD_LAT);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  alu_op_t          dec_op;
  logic             dec_md;
  logic             dec_ill;
  logic             accept;

  alu_decode #(.MD_EN(MD_EN)) u_decode (
    .aluop   (aluop),
    .funct3  (funct3),
    .funct7  (funct7),
    .op      (dec_op),
    .is_md   (dec_md),
    .illegal (dec_ill)
  );

  // Ready depends only on state and downstream ready, never on in_valid.
  always_comb begin
    in_ready = 1'b0;
    case (state)
      ST_IDLE: in_ready = 1'b1;
      ST_OUT:  in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
  end

  assign accept = in_valid && in_ready;

  // Sequencer FSM with the latency counter and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      cnt          <= CNT_ZERO;
      aluoperation <= {OP_W{1'b0}};
      out_valid    <= 1'b0;
      is_md        <= 1'b0;
      illegal      <= 1'b0;
      md_start     <= 1'b0;
      md_busy      <= 1'b0;
    end else begin
      md_start <= 1'b0;
      if (accept) begin
        aluoperation <= OP_W'(dec_op);
        is_md        <= dec_md;
        illegal      <= dec_ill;
        if (dec_md) begin
          state     <= ST_MD_RUN;
          cnt       <= CNT_LOAD;
          md_start  <= 1'b1;
          md_busy   <= 1'b1;
          out_valid <= 1'b0;
        end else begin
          state     <= ST_OUT;
          cnt       <= CNT_ZERO;
          md_busy   <= 1'b0;
          out_valid <= 1'b1;
        end
      end else begin
        case (state)
          ST_IDLE: begin
            out_valid <= 1'b0;
          end
          ST_MD_RUN: begin
            if (cnt == CNT_ONE) begin
              state     <= ST_OUT;
              cnt       <= CNT_ZERO;
              md_busy   <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end
          ST_OUT: begin
            if (out_ready) begin
              state     <= ST_IDLE;
              out_valid <= 1'b0;
            end else begin
              out_valid <= 1'b1;
            end
          end
          default: begin
            state     <= ST_IDLE;
            cnt       <= CNT_ZERO;
            out_valid <= 1'b0;
            md_busy   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
